uart_burst_sender: RTL
======================

// Module: uart_burst_sender
// PURPOSE
//  Packet-level front end for async_transmitter. Buffers bytes tagged with an end-of-packet
//  flag and feeds them back-to-back to the byte transmitter. After each packet it holds the
//  line idle for a guaranteed gap, so async_receiver at the far end raises RxD_endofpacket.
// PARAMETERS
//  ClkFrequency   50000000  clock rate in Hz
//  Baud           115200    line rate; BIT_CYCLES = ClkFrequency/Baud (integer divide, 434 at defaults)
//  FifoDepthLog2  4         FIFO depth = 2**FifoDepthLog2 entries of {last,data[7:0]}
//  GapBits        4         idle bit-times after a packet; GAP_CYCLES = GapBits*BIT_CYCLES; GapBits>=3
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous, active-high reset
//  wr_en       in   1   push {wr_last,wr_data} when wr_full==0
//  wr_data     in   8   byte to send
//  wr_last     in   1   byte is the final byte of its packet
//  wr_full     out  1   FIFO full; writes this cycle are dropped
//  wr_overflow out  1   one-cycle pulse: wr_en while wr_full (byte dropped)
//  fifo_level  out  FifoDepthLog2+1  current FIFO occupancy
//  tx_start    out  1   one-cycle start strobe to async_transmitter TxD_start
//  tx_data     out  8   byte to async_transmitter TxD_data; stable while tx_start high
//  tx_busy     in   1   async_transmitter TxD_busy
//  pkt_sent    out  1   one-cycle pulse when a packet's final line byte has finished (tx_busy fell)
//  stall       out  1   high while mid-packet with FIFO empty (writer underrun)
// BEHAVIOUR
//  - Reset: all outputs 0 (wr_full 0, fifo_level 0); FIFO emptied, FSM -> IDLE, gap counter 0.
//    Reset mid-byte: byte already in async_transmitter completes on its own; no new tx_start.
//  - FIFO: synchronous, first-word-fall-through. wr_full is a registered flag; a write with
//    wr_full==1 is dropped even if a pop occurs the same cycle. Pop and push same cycle when
//    neither full nor empty: level unchanged. Pointers wrap modulo depth.
//  - FSM: IDLE -> START when FIFO non-empty and tx_busy==0.
//    START: tx_start=1 for exactly one cycle, tx_data=head byte, pop; -> ARM.
//    ARM: wait for tx_busy==1 (rises one cycle after tx_start); -> DRAIN.
//    DRAIN: wait tx_busy==0. If popped byte had last==0: -> START if FIFO non-empty, else
//    stay in NEXT with stall=1 until a byte arrives. If last==1: -> CSUM (if enabled) else GAP.
//    GAP: count GAP_CYCLES clocks with tx_start held 0; pkt_sent pulses on GAP entry;
//    at terminal count -> IDLE (or straight to START if FIFO non-empty).
//  - Back-to-back bytes within a packet: next tx_start issued the cycle after tx_busy falls
//    (1 idle clk between frames); never issue tx_start while tx_busy==1.
//  - wr_last on an otherwise empty packet is a 1-byte packet. Writes accepted in every state.
//  - Latency: first byte of a packet into empty FIFO in IDLE -> tx_start 2 clks after wr_en.
// CONFIGURATION
//  UART_BURST_CHECKSUM_EN defined: 8-bit running sum (mod 256) of every data byte of the packet,
//   cleared on GAP exit/reset; after the last byte drains, state CSUM issues one extra
//   tx_start with tx_data=sum, ARM/DRAIN as for data, then GAP; pkt_sent on GAP entry.
//  Not defined: no CSUM state, no sum register; last byte drains directly to GAP.
// STRUCTURE
//  - uart_pkg: FSM state encoding (IDLE,START,ARM,DRAIN,NEXT,CSUM,GAP), BIT_CYCLES/GAP_CYCLES
//    calc function, FIFO entry width constant (9).
//  - One sub-module: uart_burst_fifo (sync FWFT FIFO, depth param, full/empty/level).
//  - Top holds FSM, gap counter (width clog2(GAP_CYCLES+1)), checksum register.
// TESTING (bench pairs DUT with async_transmitter + async_receiver, defaults)
//  - Write 0x41,0x42,0x43(last) -> receiver gets 0x41,0x42,0x43 then one RxD_endofpacket;
//    no tx_start for 1736 clks after last tx_busy fall.
//  - Two packets {0x10(last)},{0x20(last)} queued together -> two pkt_sent pulses, gap >=1736
//    clks between them, two RxD_endofpacket pulses.
//  - Fill 16 entries with tx_busy forced 1, write 17th -> wr_full=1, wr_overflow pulse, level=16,
//    17th byte never transmitted.
//  - Write 0x55 (last=0), wait 3000 clks, write 0xAA(last) -> stall=1 during wait, both sent,
//    pkt_sent only after 0xAA.
//  - Assert rst while tx_busy=1 mid-packet -> tx_start stays 0, level=0, no pkt_sent.
//  - With UART_BURST_CHECKSUM_EN: send 0xF0,0x20(last) -> line carries 0xF0,0x20,0x10.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the UART burst sender and its FIFO.
package uart_pkg;

    localparam int unsigned ENTRY_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ARM,
        DRAIN,
        NEXT,
        CSUM,
        GAP
    } burstState_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifoEntry_t;

    function automatic int unsigned calcBitCycles(input int unsigned clkFrequency,
                                                  input int unsigned baud);
        return clkFrequency / baud;
    endfunction

    function automatic int unsigned calcGapCycles(input int unsigned clkFrequency,
                                                  input int unsigned baud,
                                                  input int unsigned gapBits);
        return gapBits * calcBitCycles(clkFrequency, baud);
    endfunction

endpackage

// File: rtl/uart_burst_fifo.sv
// Synchronous first-word-fall-through FIFO of {last,data} entries with registered
// full/empty/level; a write while full is dropped even if a pop happens that cycle.
module uart_burst_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DepthLog2 = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wrEn,
    input  fifoEntry_t         wrEntry,
    input  logic               rdEn,
    output fifoEntry_t         rdEntry,
    output logic               full,
    output logic               empty,
    output logic [DepthLog2:0] level
);

    localparam int unsigned DEPTH = 1 << DepthLog2;
    localparam int unsigned LVL_W = DepthLog2 + 1;

    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [DepthLog2-1:0] wrPtr;
    logic [DepthLog2-1:0] rdPtr;
    logic                 push;
    logic                 pop;
    logic [DepthLog2:0]   levelNext;

    assign push      = wrEn && !full;
    assign pop       = rdEn && !empty;
    assign levelNext = level + LVL_W'(push) - LVL_W'(pop);
    assign rdEntry   = fifoEntry_t'(mem[rdPtr]);

    // Storage carries no reset; pointers and flags define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= wrEntry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + DepthLog2'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + DepthLog2'(1);
            end
            level <= levelNext;
            full  <= (levelNext == LVL_W'(DEPTH));
            empty <= (levelNext == '0);
        end
    end

endmodule

// File: rtl/uart_burst_sender.sv
// Packet front end for async_transmitter: FIFO-buffered bytes sent back-to-back, then an
// idle gap per packet. Define UART_BURST_CHECKSUM_EN to append a mod-256 sum byte.
module uart_burst_sender
    import uart_pkg::*;
#(
    parameter int unsigned ClkFrequency  = 50000000,
    parameter int unsigned Baud          = 115200,
    parameter int unsigned FifoDepthLog2 = 4,
    parameter int unsigned GapBits       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   wr_last,
    output logic                   wr_full,
    output logic                   wr_overflow,
    output logic [FifoDepthLog2:0] fifo_level,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic                   pkt_sent,
    output logic                   stall
);

    localparam int unsigned GAP_CYCLES = calcGapCycles(ClkFrequency, Baud, GapBits);
    localparam int unsigned GAP_W      = $clog2(GAP_CYCLES + 1);

    burstState_t      state;
    fifoEntry_t       wrEntry;
    fifoEntry_t       head;
    logic             fifoEmpty;
    logic             popNow;
    logic             curLast;
    logic [GAP_W-1:0] gapCnt;
    logic             gapDone;
`ifdef UART_BURST_CHECKSUM_EN
    logic [7:0]       csumSum;
    logic             csumSent;
`endif

    assign wrEntry = '{last: wr_last, data: wr_data};
    assign gapDone = (gapCnt == GAP_W'(GAP_CYCLES - 1));

    uart_burst_fifo #(
        .DepthLog2 (FifoDepthLog2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wrEn    (wr_en),
        .wrEntry (wrEntry),
        .rdEn    (popNow),
        .rdEntry (head),
        .full    (wr_full),
        .empty   (fifoEmpty),
        .level   (fifo_level)
    );

    // A byte is launched (and popped) on the edge that enters START
    always_comb begin
        popNow = 1'b0;
        if (!fifoEmpty && !tx_busy) begin
            unique case (state)
                IDLE, NEXT: popNow = 1'b1;
                DRAIN:      popNow = !curLast;
                GAP:        popNow = gapDone;
                default:    popNow = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_overflow <= 1'b0;
        end else begin
            wr_overflow <= wr_en && wr_full;
        end
    end

`ifdef UART_BURST_CHECKSUM_EN
    // Running packet sum; the first byte popped out of GAP restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csumSum <= '0;
        end else if (popNow) begin
            csumSum <= ((state == GAP) ? 8'd0 : csumSum) + head.data;
        end else if (state == GAP && gapDone) begin
            csumSum <= '0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            pkt_sent <= 1'b0;
            stall    <= 1'b0;
            curLast  <= 1'b0;
            gapCnt   <= '0;
`ifdef UART_BURST_CHECKSUM_EN
            csumSent <= 1'b0;
`endif
        end else begin
            tx_start <= 1'b0;
            pkt_sent <= 1'b0;
            if (popNow) begin
                tx_start <= 1'b1;
                tx_data  <= head.data;
                curLast  <= head.last;
            end
            case (state)
                IDLE: begin
                    if (popNow) begin
                        state <= START;
                    end
                end
                START: begin
                    state <= ARM;
                end
                ARM: begin
                    if (tx_busy) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!tx_busy) begin
                        if (!curLast) begin
                            if (popNow) begin
                                state <= START;
                            end else begin
                                state <= NEXT;
                                stall <= 1'b1;
                            end
`ifdef UART_BURST_CHECKSUM_EN
                        end else if (!csumSent) begin
                            state    <= CSUM;
                            tx_start <= 1'b1;
                            tx_data  <= csumSum;
                            csumSent <= 1'b1;
                        end else begin
                            state    <= GAP;
                            pkt_sent <= 1'b1;
                            gapCnt   <= '0;
                            csumSent <= 1'b0;
                        end
`else
                        end else begin
                            state    <= GAP;
                            pkt_sent <= 1'b1;
                            gapCnt   <= '0;
                        end
`endif
                    end
                end
                NEXT: begin
                    if (popNow) begin
                        state <= START;
                        stall <= 1'b0;
                    end
                end
`ifdef UART_BURST_CHECKSUM_EN
                CSUM: begin
                    state <= ARM;
                end
`endif
                GAP: begin
                    if (gapDone) begin
                        gapCnt <= '0;
                        state  <= popNow ? START : IDLE;
                    end else begin
                        gapCnt <= gapCnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
